// File: rtl/ddr_pmon_ctrl.sv
// Process-monitor measurement sequencer: pulses the NOR/NAND PMON enables,
// accumulates 2^N count samples and publishes truncated averages.
module ddr_pmon_ctrl #(
  parameter int CNT_W        = 24,
  parameter int MAX_AVG_LOG2 = 4,
  parameter int OFF_CYC      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [2:0]       i_avg_log2,
  input  logic [15:0]      i_timeout,
  input  logic             i_clr_err,
  input  logic             i_pmon_done_nor,
  input  logic             i_pmon_done_nand,
  input  logic [CNT_W-1:0] i_pmon_count_nor,
  input  logic [CNT_W-1:0] i_pmon_count_nand,
  output logic             o_pmon_en_nor,
  output logic             o_pmon_en_nand,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err_timeout,
  output logic [CNT_W-1:0] o_count_nor,
  output logic [CNT_W-1:0] o_count_nand
);

  localparam int ACC_W = CNT_W + MAX_AVG_LOG2;
  localparam int SMP_W = MAX_AVG_LOG2 + 1;
  localparam int OFF_W = $clog2(OFF_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EN_NOR, S_OFF_NOR, S_EN_NAND, S_OFF_NAND, S_UPDATE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         sync_nor_q, sync_nor_d, sync_nand_q, sync_nand_d;
  logic [1:0]         mode_q, mode_d;
  logic [2:0]         log2_q, log2_d;
  logic [ACC_W-1:0]   acc_nor_q, acc_nor_d, acc_nand_q, acc_nand_d;
  logic [SMP_W-1:0]   smp_cnt_q, smp_cnt_d;
  logic [15:0]        timer_q, timer_d;
  logic [OFF_W-1:0]   off_cnt_q, off_cnt_d;
  logic               aborted_q, aborted_d;
  logic               en_nor_q, en_nor_d, en_nand_q, en_nand_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [CNT_W-1:0]   count_nor_q, count_nor_d, count_nand_q, count_nand_d;

  logic               done_nor, done_nand;
  logic               set_err, end_sample, timed_out, off_elapsed;
  logic [SMP_W-1:0]   smp_inc;
  logic [ACC_W-1:0]   avg_nor, avg_nand;

  assign done_nor    = sync_nor_q[1];
  assign done_nand   = sync_nand_q[1];
  assign timed_out   = (i_timeout != '0) && (timer_q == i_timeout);
  assign off_elapsed = off_cnt_q >= OFF_W'(OFF_CYC - 1);
  assign smp_inc     = smp_cnt_q + SMP_W'(1);
  assign avg_nor     = acc_nor_q >> log2_q;
  assign avg_nand    = acc_nand_q >> log2_q;

  always_comb begin
    sync_nor_d   = {sync_nor_q[0], i_pmon_done_nor};
    sync_nand_d  = {sync_nand_q[0], i_pmon_done_nand};
    state_d      = state_q;
    mode_d       = mode_q;
    log2_d       = log2_q;
    acc_nor_d    = acc_nor_q;
    acc_nand_d   = acc_nand_q;
    smp_cnt_d    = smp_cnt_q;
    timer_d      = timer_q;
    off_cnt_d    = off_cnt_q;
    aborted_d    = aborted_q;
    count_nor_d  = count_nor_q;
    count_nand_d = count_nand_q;
    done_d       = 1'b0;
    set_err      = 1'b0;
    end_sample   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start && (i_mode != 2'b00)) begin
          mode_d     = i_mode;
          log2_d     = (i_avg_log2 > 3'(MAX_AVG_LOG2)) ? 3'(MAX_AVG_LOG2) : i_avg_log2;
          acc_nor_d  = '0;
          acc_nand_d = '0;
          smp_cnt_d  = '0;
          timer_d    = '0;
          aborted_d  = 1'b0;
          state_d    = i_mode[0] ? S_EN_NOR : S_EN_NAND;
        end
      end
      S_EN_NOR: begin
        if (done_nor) begin
          acc_nor_d = acc_nor_q + ACC_W'(i_pmon_count_nor);
          off_cnt_d = '0;
          state_d   = S_OFF_NOR;
        end else if (timed_out) begin
          set_err   = 1'b1;
          aborted_d = 1'b1;
          off_cnt_d = '0;
          state_d   = S_OFF_NOR;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_OFF_NOR: begin
        if (!off_elapsed) begin
          off_cnt_d = off_cnt_q + OFF_W'(1);
        end else if (!done_nor) begin
          timer_d = '0;
          if (aborted_q)      state_d = S_IDLE;
          else if (mode_q[1]) state_d = S_EN_NAND;
          else                end_sample = 1'b1;
        end
      end
      S_EN_NAND: begin
        if (done_nand) begin
          acc_nand_d = acc_nand_q + ACC_W'(i_pmon_count_nand);
          off_cnt_d  = '0;
          state_d    = S_OFF_NAND;
        end else if (timed_out) begin
          set_err   = 1'b1;
          aborted_d = 1'b1;
          off_cnt_d = '0;
          state_d   = S_OFF_NAND;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_OFF_NAND: begin
        if (!off_elapsed) begin
          off_cnt_d = off_cnt_q + OFF_W'(1);
        end else if (!done_nand) begin
          timer_d = '0;
          if (aborted_q) state_d = S_IDLE;
          else           end_sample = 1'b1;
        end
      end
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Results are loaded on entry to UPDATE so they are valid in the o_done cycle.
    if (end_sample) begin
      smp_cnt_d = smp_inc;
      if (smp_inc == (SMP_W'(1) << log2_q)) begin
        state_d = S_UPDATE;
        done_d  = 1'b1;
        if (mode_q[0]) count_nor_d  = avg_nor[CNT_W-1:0];
        if (mode_q[1]) count_nand_d = avg_nand[CNT_W-1:0];
      end else begin
        state_d = mode_q[0] ? S_EN_NOR : S_EN_NAND;
      end
    end

    en_nor_d  = (state_d == S_EN_NOR);
    en_nand_d = (state_d == S_EN_NAND);
    busy_d    = (state_d != S_IDLE);
    err_d     = err_q;
    if (i_clr_err) err_d = 1'b0;
    if (set_err)   err_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      sync_nor_q   <= '0;
      sync_nand_q  <= '0;
      mode_q       <= '0;
      log2_q       <= '0;
      acc_nor_q    <= '0;
      acc_nand_q   <= '0;
      smp_cnt_q    <= '0;
      timer_q      <= '0;
      off_cnt_q    <= '0;
      aborted_q    <= 1'b0;
      en_nor_q     <= 1'b0;
      en_nand_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      count_nor_q  <= '0;
      count_nand_q <= '0;
    end else begin
      state_q      <= state_d;
      sync_nor_q   <= sync_nor_d;
      sync_nand_q  <= sync_nand_d;
      mode_q       <= mode_d;
      log2_q       <= log2_d;
      acc_nor_q    <= acc_nor_d;
      acc_nand_q   <= acc_nand_d;
      smp_cnt_q    <= smp_cnt_d;
      timer_q      <= timer_d;
      off_cnt_q    <= off_cnt_d;
      aborted_q    <= aborted_d;
      en_nor_q     <= en_nor_d;
      en_nand_q    <= en_nand_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      count_nor_q  <= count_nor_d;
      count_nand_q <= count_nand_d;
    end
  end

  assign o_pmon_en_nor  = en_nor_q;
  assign o_pmon_en_nand = en_nand_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_err_timeout  = err_q;
  assign o_count_nor    = count_nor_q;
  assign o_count_nand   = count_nand_q;

endmodule

// File: tb/tb_ddr_pmon_ctrl.sv
// Scoreboard bench for ddr_pmon_ctrl: a PMON responder model answers the enables,
// expected run results are queued at start and checked when o_done pulses.
module tb_ddr_pmon_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = '0;
  logic [2:0]  avg_log2 = '0;
  logic [15:0] timeout = '0;
  logic        clr_err = 1'b0;
  logic        done_nor = 1'b0, done_nand = 1'b0;
  logic [23:0] cnt_nor = '0, cnt_nand = '0;
  logic        en_nor, en_nand, busy, done, err;
  logic [23:0] out_nor, out_nand;

  always #5 clk = ~clk;

  ddr_pmon_ctrl #(.CNT_W(24), .MAX_AVG_LOG2(4), .OFF_CYC(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode),
    .i_avg_log2(avg_log2), .i_timeout(timeout), .i_clr_err(clr_err),
    .i_pmon_done_nor(done_nor), .i_pmon_done_nand(done_nand),
    .i_pmon_count_nor(cnt_nor), .i_pmon_count_nand(cnt_nand),
    .o_pmon_en_nor(en_nor), .o_pmon_en_nand(en_nand), .o_busy(busy),
    .o_done(done), .o_err_timeout(err), .o_count_nor(out_nor), .o_count_nand(out_nand)
  );

  typedef struct {
    logic [23:0] nor_v;
    logic [23:0] nand_v;
    int          pn;
    int          pa;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // PMON responder configuration
  int          nor_delay = 20, nand_delay = 20, nor_hold = 0, nand_hold = 0;
  bit          nand_never = 1'b0;
  logic [23:0] nor_q[$], nand_q[$];

  initial begin : resp_nor
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        done_nor = 1'b0; c = 0;
      end else if (en_nor && !done_nor) begin
        c++;
        if (c >= nor_delay) begin
          cnt_nor  = (nor_q.size() > 0) ? nor_q.pop_front() : 24'd0;
          done_nor = 1'b1; c = 0;
        end
      end else if (!en_nor && done_nor) begin
        c++;
        if (c > nor_hold) begin done_nor = 1'b0; c = 0; end
      end else c = 0;
    end
  end

  initial begin : resp_nand
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        done_nand = 1'b0; c = 0;
      end else if (en_nand && !done_nand) begin
        c++;
        if (!nand_never && c >= nand_delay) begin
          cnt_nand  = (nand_q.size() > 0) ? nand_q.pop_front() : 24'd0;
          done_nand = 1'b1; c = 0;
        end
      end else if (!en_nand && done_nand) begin
        c++;
        if (c > nand_hold) begin done_nand = 1'b0; c = 0; end
      end else c = 0;
    end
  end

  // Monitor: enable pulse bookkeeping and result checking on o_done
  int   pulses_nor = 0, pulses_nand = 0, overlap = 0;
  int   gap_nor = 0, last_gap_nor = 0, min_gap_nor = 1000, nand_hi = 0;
  logic prev_nor = 1'b0, prev_nand = 1'b0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pulses_nor = 0; pulses_nand = 0; gap_nor = 0; prev_nor = 1'b0; prev_nand = 1'b0;
      end else begin
        if (en_nor && en_nand) overlap++;
        if (en_nor && !prev_nor) begin
          pulses_nor++;
          if (pulses_nor > 1) begin
            last_gap_nor = gap_nor;
            if (gap_nor < min_gap_nor) min_gap_nor = gap_nor;
          end
        end
        gap_nor = en_nor ? 0 : gap_nor + 1;
        if (en_nand && !prev_nand) begin
          pulses_nand++;
          nand_hi = 0;
        end
        if (en_nand) nand_hi++;
        if (done) begin
          if (sb.size() == 0) check("unexpected_done", 1, 0);
          else begin
            e = sb.pop_front();
            check("count_nor", out_nor, e.nor_v);
            check("count_nand", out_nand, e.nand_v);
            check("pulses_nor", pulses_nor, e.pn);
            check("pulses_nand", pulses_nand, e.pa);
          end
        end
        if (!busy) begin pulses_nor = 0; pulses_nand = 0; end
        prev_nor = en_nor; prev_nand = en_nand;
      end
    end
  end

  task automatic pulse_start(input logic [1:0] m, input logic [2:0] l);
    @(negedge clk);
    start = 1'b1; mode = m; avg_log2 = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    check("busy_bound", busy, 0);
    @(negedge clk);
  endtask

  task automatic run(input logic [1:0] m, input logic [2:0] l, input exp_t e);
    sb.push_back(e);
    pulse_start(m, l);
    wait_idle();
  endtask

  initial begin
    exp_t e;
    int n;
    #12;
    check("rst_outputs", {en_nor, en_nand, busy, done, err, out_nor, out_nand}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single NOR sample
    nor_q.push_back(24'h001234);
    e = '{24'h001234, 24'd0, 1, 0};
    run(2'b01, 3'd0, e);

    // 2: interleaved NOR/NAND, 4 samples
    nor_q.push_back(24'd100); nor_q.push_back(24'd102);
    nor_q.push_back(24'd98);  nor_q.push_back(24'd104);
    for (int i = 0; i < 4; i++) nand_q.push_back(24'd200);
    e = '{24'd101, 24'd200, 4, 4};
    run(2'b11, 3'd2, e);

    // 3: NAND timeout aborts the run
    nand_never = 1'b1; timeout = 16'd50;
    pulse_start(2'b10, 3'd0);
    wait_idle();
    check("timeout_err", err, 1);
    check("timeout_len_ok", (nand_hi >= 50 && nand_hi <= 51), 1);
    check("timeout_keep", {out_nor, out_nand}, {24'd101, 24'd200});
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    check("clr_err", err, 0);
    nand_never = 1'b0; timeout = '0;

    // 4: done held long after enable drops
    nor_hold = 30;
    nor_q.push_back(24'd10); nor_q.push_back(24'd13);
    e = '{24'd11, 24'd200, 2, 0};
    run(2'b01, 3'd1, e);
    check("hold_gap_ok", (last_gap_nor > 30 && last_gap_nor < 40), 1);
    nor_hold = 0;

    // 5: start while busy ignored, mode 00 ignored, log2 clamps to 4
    nor_q.push_back(24'h55);
    sb.push_back('{24'h55, 24'd200, 1, 0});
    pulse_start(2'b01, 3'd0);
    repeat (8) @(negedge clk);
    pulse_start(2'b11, 3'd2);
    wait_idle();
    pulse_start(2'b00, 3'd0);
    check("mode0_idle_a", busy, 0);
    @(negedge clk);
    check("mode0_idle_b", busy, 0);
    nor_delay = 3;
    for (int i = 0; i < 16; i++) nor_q.push_back(24'(1000 + i));
    e = '{24'd1007, 24'd200, 16, 0};
    run(2'b01, 3'd7, e);

    // 6: asynchronous reset mid-run
    nor_delay = 40;
    nor_q.push_back(24'h99);
    pulse_start(2'b01, 3'd0);
    n = 0;
    while (!en_nor && n < 100) begin @(negedge clk); n++; end
    check("en_before_rst", en_nor, 1);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {en_nor, en_nand, busy, done, err, out_nor, out_nand}, 0);
    nor_q.delete(); nand_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    nor_delay = 5; nand_delay = 5;
    nor_q.push_back(24'd7); nand_q.push_back(24'd9);
    e = '{24'd7, 24'd9, 1, 1};
    run(2'b11, 3'd0, e);

    check("sb_empty", sb.size(), 0);
    check("no_overlap", overlap, 0);
    check("min_off_gap_ok", (min_gap_nor >= 8), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
